// File: rtl/apb_rr_stuff_engine_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_rr_stuff_engine_if : APB register port, req/ack source, rdy/vld source
//                          stream and notify/ack completion handshake.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface apb_rr_stuff_engine_if #(
  parameter int DATA_W = 4
);
  localparam int OUT_W = DATA_W + 1;

  logic [31:0]       apbReg_paddr;
  logic              apbReg_psel;
  logic              apbReg_penable;
  logic              apbReg_pwrite;
  logic [31:0]       apbReg_pwdata;
  logic              apbReg_pready;
  logic [31:0]       apbReg_prdata;
  logic              apbReg_pslverr;

  logic              aStuffIf_req;
  logic [DATA_W-1:0] aStuffIf_data;
  logic              aStuffIf_ack;
  logic              aStuffIf_rdata;

  logic              cStuffIf_vld;
  logic [OUT_W-1:0]  cStuffIf_data;
  logic              cStuffIf_rdy;

  logic              startDone_notify;
  logic              startDone_ack;

  modport slave (
    input  apbReg_paddr, apbReg_psel, apbReg_penable, apbReg_pwrite, apbReg_pwdata,
    output apbReg_pready, apbReg_prdata, apbReg_pslverr,
    output aStuffIf_req, aStuffIf_data,
    input  aStuffIf_ack, aStuffIf_rdata,
    output cStuffIf_vld, cStuffIf_data,
    input  cStuffIf_rdy,
    output startDone_notify,
    input  startDone_ack
  );

  modport master (
    output apbReg_paddr, apbReg_psel, apbReg_penable, apbReg_pwrite, apbReg_pwdata,
    input  apbReg_pready, apbReg_prdata, apbReg_pslverr,
    input  aStuffIf_req, aStuffIf_data,
    output aStuffIf_ack, aStuffIf_rdata,
    input  cStuffIf_vld, cStuffIf_data,
    output cStuffIf_rdy,
    input  startDone_notify,
    output startDone_ack
  );
endinterface
`default_nettype wire

// File: rtl/apb_rr_stuff_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_rr_stuff_engine : APB-programmed multi-channel round-robin req/ack engine.
// Revision: 1.0
// ----------------------------------------------------------------------------
module apb_rr_stuff_engine #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input wire                   clk,
  input wire                   rst,
  apb_rr_stuff_engine_if.slave io_bus
);
  localparam int OUT_W = DATA_W + 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [5:0]       c_idx_end = 6'(2 + 2 * NUM_CH);
  localparam logic [CH_W-1:0]  c_last_ch = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_REQ    = 3'd2,
    S_OUT    = 3'd3,
    S_NOTIFY = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_count     [NUM_CH];
  logic [DATA_W-1:0] r_seed      [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [CNT_W-1:0]  r_remaining [NUM_CH];
  logic [CNT_W-1:0]  r_result    [NUM_CH];
  logic [CH_W-1:0]   r_last_grant, r_grant;
  logic [DATA_W-1:0] r_req_data;
  logic              r_rdata, r_busy, r_done, r_aborted, r_abort_pend;

  logic              w_acc, w_wr, w_wr_ok, w_err, w_start, w_abort;
  logic              w_in_range, w_is_ctrl, w_is_stat, w_is_cfg, w_is_res;
  logic [5:0]        w_idx, w_ch_off;
  logic [CH_W-1:0]   w_ch;
  logic [31:0]       w_rd_word;
  logic              w_found;
  logic [CH_W-1:0]   w_pick;
  logic [CH_W:0]     w_cand;
  logic              w_req, w_vld, w_notify;
  logic              w_unused;

  // Register index: 0 CTRL, 1 STATUS, then CH_CFG/CH_RESULT pairs per channel.
  assign w_acc      = io_bus.apbReg_psel & io_bus.apbReg_penable;
  assign w_wr       = w_acc & io_bus.apbReg_pwrite;
  assign w_idx      = io_bus.apbReg_paddr[7:2];
  assign w_ch_off   = (w_idx - 6'd2) >> 1;
  assign w_ch       = w_ch_off[CH_W-1:0];
  assign w_in_range = (w_idx < c_idx_end);
  assign w_is_ctrl  = (w_idx == 6'd0);
  assign w_is_stat  = (w_idx == 6'd1);
  assign w_is_cfg   = w_in_range && (w_idx >= 6'd2) && !w_idx[0];
  assign w_is_res   = w_in_range && (w_idx >= 6'd2) && w_idx[0];
  assign w_err      = w_acc & (!w_in_range | (w_is_cfg & io_bus.apbReg_pwrite & r_busy));
  assign w_wr_ok    = w_wr & !w_err;
  assign w_start    = w_wr_ok & w_is_ctrl & io_bus.apbReg_pwdata[0] & (r_state == S_IDLE);
  assign w_abort    = w_wr_ok & w_is_ctrl & io_bus.apbReg_pwdata[1] & r_busy;
  assign w_unused   = ^{io_bus.apbReg_paddr[31:8], io_bus.apbReg_paddr[1:0],
                        io_bus.apbReg_pwdata, w_ch_off};

  always_comb begin
    w_rd_word = '0;
    if (w_is_stat) begin
      w_rd_word[2:0] = {r_aborted, r_done, r_busy};
    end else if (w_is_cfg) begin
      w_rd_word[CNT_W-1:0]   = r_count[w_ch];
      w_rd_word[16 +: DATA_W] = r_seed[w_ch];
      w_rd_word[31]          = r_en[w_ch];
    end else if (w_is_res) begin
      w_rd_word[CNT_W-1:0] = r_result[w_ch];
    end
  end

  assign io_bus.apbReg_pready  = w_acc;
  assign io_bus.apbReg_pslverr = w_err;
  assign io_bus.apbReg_prdata  = (w_acc && !w_err) ? w_rd_word : 32'd0;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last_grant;
    w_cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand = {1'b0, r_last_grant} + (CH_W+1)'(i);
      if (w_cand >= (CH_W+1)'(NUM_CH)) w_cand = w_cand - (CH_W+1)'(NUM_CH);
      if (!w_found && (r_remaining[w_cand[CH_W-1:0]] != '0)) begin
        w_found = 1'b1;
        w_pick  = w_cand[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_vld       = 1'b0;
    w_notify    = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_ARB;
      S_ARB:    w_state_nxt = (r_abort_pend || !w_found) ? S_NOTIFY : S_REQ;
      S_REQ: begin
        w_req = 1'b1;
        if (io_bus.aStuffIf_ack) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_vld = 1'b1;
        if (io_bus.cStuffIf_rdy) w_state_nxt = S_ARB;
      end
      S_NOTIFY: begin
        w_notify = 1'b1;
        if (io_bus.startDone_ack) w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_count[c]     <= '0;
        r_seed[c]      <= '0;
        r_remaining[c] <= '0;
        r_result[c]    <= '0;
      end
      r_en         <= '0;
      r_last_grant <= c_last_ch;
      r_grant      <= '0;
      r_req_data   <= '0;
      r_rdata      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_wr_ok && w_is_cfg) begin
        r_count[w_ch] <= io_bus.apbReg_pwdata[CNT_W-1:0];
        r_seed[w_ch]  <= io_bus.apbReg_pwdata[16 +: DATA_W];
        r_en[w_ch]    <= io_bus.apbReg_pwdata[31];
      end
      if (w_wr_ok && w_is_stat) begin
        if (io_bus.apbReg_pwdata[1]) r_done    <= 1'b0;
        if (io_bus.apbReg_pwdata[2]) r_aborted <= 1'b0;
      end
      if (w_start) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_remaining[c] <= r_en[c] ? r_count[c] : '0;
          r_result[c]    <= '0;
        end
        r_busy <= 1'b1;
      end
      if (w_abort) r_abort_pend <= 1'b1;
      // Sticky sets come after the W1C clears so a same-cycle set wins.
      case (r_state)
        S_ARB: if (!r_abort_pend && w_found) begin
          r_grant      <= w_pick;
          r_last_grant <= w_pick;
          r_req_data   <= r_seed[w_pick] + DATA_W'(r_count[w_pick] - r_remaining[w_pick]);
        end
        S_REQ: if (io_bus.aStuffIf_ack) r_rdata <= io_bus.aStuffIf_rdata;
        S_OUT: if (io_bus.cStuffIf_rdy) begin
          r_remaining[r_grant] <= r_remaining[r_grant] - c_cnt_one;
          if (r_rdata) r_result[r_grant] <= r_result[r_grant] + c_cnt_one;
        end
        S_NOTIFY: if (io_bus.startDone_ack) begin
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
          if (r_abort_pend) r_aborted <= 1'b1;
          r_abort_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.aStuffIf_req     = w_req;
  assign io_bus.aStuffIf_data    = w_req ? r_req_data : '0;
  assign io_bus.cStuffIf_vld     = w_vld;
  assign io_bus.cStuffIf_data    = w_vld ? {r_rdata, r_req_data} : OUT_W'(0);
  assign io_bus.startDone_notify = w_notify;
endmodule
`default_nettype wire

// File: tb/tb_apb_rr_stuff_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb_rr_stuff_engine : randomized bench with a queue-based round-robin model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_apb_rr_stuff_engine;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_rr_stuff_engine_if #(.DATA_W(DATA_W)) bus ();

  apb_rr_stuff_engine #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Responder: random stalls, ack/rdy noise while idle, records every transaction.
  int                max_stall   = 0;
  int                fixed_stall = -1;
  logic              hold_rdy    = 1'b0;
  logic              rd_plan[$];
  logic [DATA_W-1:0] obs_req_q[$];
  logic              obs_rd_q[$];
  logic              prev_req = 1'b0, prev_vld = 1'b0, prev_ntf = 1'b0;
  logic [DATA_W-1:0] cur_req  = '0;
  logic              cur_rd   = 1'b0;
  int                req_stall = 0, vld_stall = 0, ntf_stall = 0;

  initial begin
    bus.aStuffIf_ack   = 1'b0;
    bus.aStuffIf_rdata = 1'b0;
    bus.cStuffIf_rdy   = 1'b0;
    bus.startDone_ack  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.aStuffIf_req) begin
        if (!prev_req) begin
          cur_req = bus.aStuffIf_data;
          obs_req_q.push_back(cur_req);
          req_stall = (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(max_stall, 0));
        end else begin
          chk("req_stable", 32'(bus.aStuffIf_data), 32'(cur_req));
        end
        if (req_stall == 0) begin
          cur_rd = (rd_plan.size() > 0) ? rd_plan.pop_front() : 1'($urandom);
          bus.aStuffIf_ack   = 1'b1;
          bus.aStuffIf_rdata = cur_rd;
          obs_rd_q.push_back(cur_rd);
        end else begin
          bus.aStuffIf_ack   = 1'b0;
          bus.aStuffIf_rdata = 1'($urandom);
          req_stall--;
        end
      end else begin
        bus.aStuffIf_ack   = 1'($urandom);
        bus.aStuffIf_rdata = 1'($urandom);
      end
      prev_req = bus.aStuffIf_req;

      if (bus.cStuffIf_vld) begin
        chk("vld_data", 32'(bus.cStuffIf_data), 32'({cur_rd, cur_req}));
        if (!prev_vld) vld_stall = int'($urandom_range(max_stall, 0));
        if (hold_rdy) bus.cStuffIf_rdy = 1'b0;
        else if (vld_stall == 0) bus.cStuffIf_rdy = 1'b1;
        else begin
          bus.cStuffIf_rdy = 1'b0;
          vld_stall--;
        end
      end else begin
        bus.cStuffIf_rdy = hold_rdy ? 1'b0 : 1'($urandom);
      end
      prev_vld = bus.cStuffIf_vld;

      if (bus.startDone_notify) begin
        if (!prev_ntf) ntf_stall = int'($urandom_range(max_stall, 0));
        if (ntf_stall == 0) bus.startDone_ack = 1'b1;
        else begin
          bus.startDone_ack = 1'b0;
          ntf_stall--;
        end
      end else begin
        bus.startDone_ack = 1'($urandom);
      end
      prev_ntf = bus.startDone_notify;
    end
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(negedge clk);
    bus.apbReg_psel    = 1'b1;
    bus.apbReg_penable = 1'b0;
    bus.apbReg_pwrite  = wr;
    bus.apbReg_paddr   = addr;
    bus.apbReg_pwdata  = wdata;
    @(negedge clk);
    bus.apbReg_penable = 1'b1;
    #1;
    rdata = bus.apbReg_prdata;
    err   = bus.apbReg_pslverr;
    chk("pready", 32'(bus.apbReg_pready), 32'd1);
    @(posedge clk);
    #1;
    bus.apbReg_psel    = 1'b0;
    bus.apbReg_penable = 1'b0;
    bus.apbReg_pwrite  = 1'b0;
  endtask

  // Reference model: channel configuration and the expected issue order.
  logic              cfg_en   [NUM_CH];
  int                cfg_cnt  [NUM_CH];
  int                cfg_seed [NUM_CH];
  int                m_last = NUM_CH - 1;
  logic [DATA_W-1:0] exp_data[$];
  int                exp_ch[$];

  task automatic model_batch();
    int  rem [NUM_CH];
    bit  any;
    int  c;
    exp_data.delete();
    exp_ch.delete();
    for (int k = 0; k < NUM_CH; k++) rem[k] = cfg_en[k] ? cfg_cnt[k] : 0;
    do begin
      any = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_last + k) % NUM_CH;
        if (!any && rem[c] > 0) begin
          any = 1'b1;
          exp_ch.push_back(c);
          exp_data.push_back(DATA_W'(cfg_seed[c] + cfg_cnt[c] - rem[c]));
          rem[c]--;
          m_last = c;
        end
      end
    end while (any);
  endtask

  task automatic set_ch(input int c, input logic en, input int seed, input int cnt);
    logic [31:0] w, r;
    logic        e;
    cfg_en[c]   = en;
    cfg_seed[c] = seed % 16;
    cfg_cnt[c]  = cnt % 256;
    w = 32'(cfg_cnt[c]) | (32'(cfg_seed[c]) << 16) | (en ? 32'h8000_0000 : 32'd0);
    apb_xfer(1'b1, 32'(8 + 8 * c), w, r, e);
    chk("cfg_wr_err", 32'(e), 32'd0);
    apb_xfer(1'b0, 32'(8 + 8 * c), 32'd0, r, e);
    chk("cfg_readback", r, w);
  endtask

  task automatic start_batch();
    logic [31:0] r;
    logic        e;
    obs_req_q.delete();
    obs_rd_q.delete();
    model_batch();
    apb_xfer(1'b1, 32'h0, 32'h1, r, e);
  endtask

  task automatic wait_idle();
    logic [31:0] r;
    logic        e;
    int          i;
    for (i = 0; i < 500; i++) begin
      apb_xfer(1'b0, 32'h4, 32'd0, r, e);
      if (r[0] == 1'b0) break;
    end
    chk("busy_timeout", 32'(i >= 500), 32'd0);
  endtask

  task automatic check_batch(input string tag);
    logic [31:0] r;
    logic        e;
    int          n, expr;
    chk({tag, "_nreq"}, 32'(obs_req_q.size()), 32'(exp_data.size()));
    n = exp_data.size();
    if (obs_req_q.size() < n) n = obs_req_q.size();
    if (obs_rd_q.size() < n)  n = obs_rd_q.size();
    for (int k = 0; k < n; k++) chk({tag, "_data"}, 32'(obs_req_q[k]), 32'(exp_data[k]));
    for (int c = 0; c < NUM_CH; c++) begin
      expr = 0;
      for (int k = 0; k < n; k++) if (exp_ch[k] == c && obs_rd_q[k]) expr++;
      apb_xfer(1'b0, 32'(12 + 8 * c), 32'd0, r, e);
      chk({tag, "_result"}, r, 32'(expr));
    end
    apb_xfer(1'b0, 32'h4, 32'd0, r, e);
    chk({tag, "_status"}, r, 32'h2);
    apb_xfer(1'b1, 32'h4, 32'h6, r, e);
    apb_xfer(1'b0, 32'h4, 32'd0, r, e);
    chk({tag, "_status_w1c"}, r, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          i;
    rst                = 1'b1;
    bus.apbReg_psel    = 1'b0;
    bus.apbReg_penable = 1'b0;
    bus.apbReg_pwrite  = 1'b0;
    bus.apbReg_paddr   = 32'd0;
    bus.apbReg_pwdata  = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_en[c] = 1'b0; cfg_cnt[c] = 0; cfg_seed[c] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req",     32'(bus.aStuffIf_req),     32'd0);
    chk("rst_adata",   32'(bus.aStuffIf_data),    32'd0);
    chk("rst_vld",     32'(bus.cStuffIf_vld),     32'd0);
    chk("rst_cdata",   32'(bus.cStuffIf_data),    32'd0);
    chk("rst_notify",  32'(bus.startDone_notify), 32'd0);
    chk("rst_prdata",  bus.apbReg_prdata,         32'd0);
    chk("rst_pslverr", 32'(bus.apbReg_pslverr),   32'd0);
    apb_xfer(1'b0, 32'h4, 32'd0, r, e);
    chk("rst_status", r, 32'h0);
    apb_xfer(1'b0, 32'h8, 32'd0, r, e);
    chk("rst_cfg0", r, 32'h0);

    // Round-robin with stalls, plus error accesses while busy
    max_stall = 5;
    set_ch(0, 1'b1, 3, 2);
    set_ch(1, 1'b0, 7, 5);
    set_ch(2, 1'b1, 9, 1);
    set_ch(3, 1'b0, 0, 0);
    start_batch();
    apb_xfer(1'b0, 32'h4, 32'd0, r, e);
    chk("rr_busy", r, 32'h1);
    apb_xfer(1'b1, 32'h10, 32'h8000_0003, r, e);
    chk("cfg_busy_err", 32'(e), 32'd1);
    apb_xfer(1'b0, 32'hFC, 32'd0, r, e);
    chk("badaddr_err", 32'(e), 32'd1);
    chk("badaddr_data", r, 32'd0);
    apb_xfer(1'b1, 32'h0, 32'h1, r, e);
    chk("start_busy_err", 32'(e), 32'd0);
    apb_xfer(1'b0, 32'h10, 32'd0, r, e);
    chk("cfg1_unchanged", r, 32'h0007_0005);
    wait_idle();
    if (obs_req_q.size() == 3) begin
      chk("rr_order0", 32'(obs_req_q[0]), 32'h3);
      chk("rr_order1", 32'(obs_req_q[1]), 32'h9);
      chk("rr_order2", 32'(obs_req_q[2]), 32'h4);
    end
    check_batch("rr");

    // Single channel with seed wrap and fixed rdata pattern
    max_stall = 0;
    set_ch(2, 1'b0, 9, 1);
    set_ch(0, 1'b1, 14, 3);
    rd_plan = '{1'b1, 1'b0, 1'b1};
    start_batch();
    chk("req_t1", 32'(bus.aStuffIf_req), 32'd0);
    @(posedge clk);
    #1;
    chk("req_t2", 32'(bus.aStuffIf_req), 32'd1);
    wait_idle();
    if (obs_req_q.size() == 3) begin
      chk("single_d0", 32'(obs_req_q[0]), 32'hE);
      chk("single_d1", 32'(obs_req_q[1]), 32'hF);
      chk("single_d2", 32'(obs_req_q[2]), 32'h0);
    end
    apb_xfer(1'b0, 32'hC, 32'd0, r, e);
    chk("single_res0", r, 32'd2);
    check_batch("single");

    // Abort while a request is stalled
    set_ch(0, 1'b1, 5, 5);
    fixed_stall = 4;
    obs_req_q.delete();
    obs_rd_q.delete();
    apb_xfer(1'b1, 32'h0, 32'h1, r, e);
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.aStuffIf_req) break;
    end
    chk("abort_req_timeout", 32'(i >= 20), 32'd0);
    apb_xfer(1'b1, 32'h0, 32'h2, r, e);
    wait_idle();
    fixed_stall = -1;
    m_last = 0;
    chk("abort_nreq", 32'(obs_req_q.size()), 32'd1);
    if (obs_req_q.size() >= 1) chk("abort_data", 32'(obs_req_q[0]), 32'h5);
    apb_xfer(1'b0, 32'h4, 32'd0, r, e);
    chk("abort_status", r, 32'h6);
    apb_xfer(1'b0, 32'hC, 32'd0, r, e);
    if (obs_rd_q.size() >= 1) chk("abort_res0", r, 32'(obs_rd_q[0]));
    apb_xfer(1'b1, 32'h4, 32'h6, r, e);

    // Randomized batches
    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < NUM_CH; c++)
        set_ch(c, 1'($urandom), int'($urandom_range(15, 0)), int'($urandom_range(4, 0)));
      max_stall = int'($urandom_range(3, 0));
      start_batch();
      wait_idle();
      check_batch("rand");
    end

    // Reset while the output stream is stalled
    max_stall = 0;
    set_ch(0, 1'b1, 2, 1);
    for (int c = 1; c < NUM_CH; c++) set_ch(c, 1'b0, 0, 0);
    hold_rdy = 1'b1;
    start_batch();
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.cStuffIf_vld) break;
    end
    chk("vld_timeout", 32'(i >= 30), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_vld",    32'(bus.cStuffIf_vld),     32'd0);
    chk("rstmid_req",    32'(bus.aStuffIf_req),     32'd0);
    chk("rstmid_notify", 32'(bus.startDone_notify), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold_rdy = 1'b0;
    apb_xfer(1'b0, 32'h4, 32'd0, r, e);
    chk("rstmid_status", r, 32'h0);
    apb_xfer(1'b0, 32'h8, 32'd0, r, e);
    chk("rstmid_cfg0", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
